// File: rtl/ubus_slave_mem.sv
// UBus slave memory responder.
// Byte-wide memory window at BASE_ADDR..BASE_ADDR+DEPTH-1; silent outside it.
// Bursts of 1/2/4/8 beats; beats that run past the window end return an
// error (reads give 8'h00, writes are dropped) without wrapping.
// Optional wait states: define UBUS_SLAVE_WAIT_EN to insert WAIT_CYCLES
// wait cycles at the start of every beat; otherwise ubus_wait is tied low.
//
// state | meaning
// IDLE  | watching for an address phase
// DATA  | burst data beats in progress
module ubus_slave_mem #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        ubus_clock,
    input  logic        ubus_reset,
    input  logic [15:0] ubus_addr,
    input  logic [1:0]  ubus_size,
    input  logic        ubus_read,
    input  logic        ubus_write,
    input  logic        ubus_bip,
    input  logic [7:0]  ubus_data_in,
    output logic [7:0]  ubus_data_out,
    output logic        ubus_data_oe,
    output logic        ubus_wait,
    output logic        ubus_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_wait_range
        $error("ubus_slave_mem: WAIT_CYCLES must be 0..7");
    end
    if (DEPTH < 16 || DEPTH > 4096 || (1 << AW) != DEPTH) begin : g_depth_range
        $error("ubus_slave_mem: DEPTH must be a power of 2 in 16..4096");
    end

    typedef enum logic {IDLE, DATA} state_t;

    state_t        state, state_nx;
    logic [7:0]    mem [DEPTH];
    logic [OW-1:0] offset;
    logic [2:0]    beat;
    logic [2:0]    last_beat;
    logic          dir_rd;

    // window decode: the borrow bit flags addresses below BASE_ADDR
    logic [16:0]   rel;
    logic          hit, start, collide;
    assign rel     = {1'b0, ubus_addr} - {1'b0, BASE_ADDR};
    assign hit     = !rel[16] && (rel < 17'(DEPTH));
    assign collide = ubus_read && ubus_write;
    assign start   = hit && (ubus_read ^ ubus_write);

    // offset < DEPTH and beat <= 7 < DEPTH, so the top bit marks out-of-window
    logic [OW-1:0] cur, nxt;
    logic          done, last;
    assign cur  = offset + OW'(beat);
    assign nxt  = cur + OW'(1);
    assign done = (state == DATA) && !ubus_wait;
    assign last = (beat == last_beat) || !ubus_bip;

`ifdef UBUS_SLAVE_WAIT_EN
    logic [2:0] wait_cnt;

    // wait counter restarts at every beat start
    always_ff @(posedge ubus_clock) begin
        if (ubus_reset || state == IDLE || done)
            wait_cnt <= 3'd0;
        else
            wait_cnt <= wait_cnt + 3'd1;
    end

    assign ubus_wait = (state == DATA) && (wait_cnt < 3'(WAIT_CYCLES));
`else
    assign ubus_wait = 1'b0;
`endif

    // state register
    always_ff @(posedge ubus_clock) begin
        if (ubus_reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state: accept a clean hit, leave DATA on the final completing beat
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = DATA;
            DATA:    if (done && last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // burst context, registered read data, oe and error
    always_ff @(posedge ubus_clock) begin
        if (ubus_reset) begin
            ubus_data_out <= 8'h00;
            ubus_data_oe  <= 1'b0;
            ubus_error    <= 1'b0;
            offset        <= '0;
            beat          <= 3'd0;
            last_beat     <= 3'd0;
            dir_rd        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ubus_data_out <= 8'h00;
                    ubus_data_oe  <= 1'b0;
                    ubus_error    <= collide && hit;
                    if (start) begin
                        offset    <= rel[AW:0];
                        beat      <= 3'd0;
                        last_beat <= {ubus_size == 2'b11, ubus_size[1], |ubus_size};
                        dir_rd    <= ubus_read;
                        if (ubus_read) begin
                            ubus_data_out <= mem[rel[AW-1:0]];
                            ubus_data_oe  <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (done) begin
                        if (last) begin
                            ubus_data_out <= 8'h00;
                            ubus_data_oe  <= 1'b0;
                            ubus_error    <= 1'b0;
                            beat          <= 3'd0;
                        end else begin
                            beat       <= beat + 3'd1;
                            ubus_error <= nxt[AW];
                            if (dir_rd)
                                ubus_data_out <= nxt[AW] ? 8'h00 : mem[nxt[AW-1:0]];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // memory write on a completing in-window write beat; reset cancels it
    always_ff @(posedge ubus_clock) begin
        if (!ubus_reset && done && !dir_rd && !cur[AW])
            mem[cur[AW-1:0]] <= ubus_data_in;
    end

endmodule

// File: tb/tb_ubus_slave_mem.sv
// Directed bench for ubus_slave_mem with a transaction-level memory model.
module tb_ubus_slave_mem;

    localparam logic [15:0] BASE  = 16'h0000;
    localparam int          DEPTH = 256;
`ifdef UBUS_SLAVE_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic        clk = 1'b0;
    logic        ubus_reset, ubus_read, ubus_write, ubus_bip;
    logic [15:0] ubus_addr;
    logic [1:0]  ubus_size;
    logic [7:0]  ubus_data_in, ubus_data_out;
    logic        ubus_data_oe, ubus_wait, ubus_error;

    logic [7:0]  exp_do;
    logic        exp_oe, exp_wt, exp_er, cap, chk;
    logic [7:0]  mem_m [DEPTH];
    logic [7:0]  rd_seen [$];
    int          oe_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    ubus_slave_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .ubus_clock   (clk),
        .ubus_reset   (ubus_reset),
        .ubus_addr    (ubus_addr),
        .ubus_size    (ubus_size),
        .ubus_read    (ubus_read),
        .ubus_write   (ubus_write),
        .ubus_bip     (ubus_bip),
        .ubus_data_in (ubus_data_in),
        .ubus_data_out(ubus_data_out),
        .ubus_data_oe (ubus_data_oe),
        .ubus_wait    (ubus_wait),
        .ubus_error   (ubus_error)
    );

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkint(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model's expectations
    always @(negedge clk) begin
        if (chk) begin
            chk8("data_out", ubus_data_out, exp_do);
            chk8("data_oe", {7'd0, ubus_data_oe}, {7'd0, exp_oe});
            chk8("wait", {7'd0, ubus_wait}, {7'd0, exp_wt});
            chk8("error", {7'd0, ubus_error}, {7'd0, exp_er});
            if (cap) rd_seen.push_back(ubus_data_out);
            if (ubus_data_oe === 1'b1) oe_cnt++;
        end
    end

    task automatic step(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] sz,
                        input logic bp, input logic [7:0] din, input logic rst,
                        input logic [7:0] e_do, input logic e_oe, input logic e_wt,
                        input logic e_er, input logic capture);
        ubus_read = rd; ubus_write = wr; ubus_addr = a; ubus_size = sz;
        ubus_bip = bp; ubus_data_in = din; ubus_reset = rst;
        exp_do = e_do; exp_oe = e_oe; exp_wt = e_wt; exp_er = e_er;
        cap = capture; chk = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic e_er);
        step(1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, e_er, 1'b0);
    endtask

    // One burst: address phase then beats. run limits the beats (early end via
    // bip=0), rst_beat asserts reset in that beat's completing cycle, noise
    // drives a read address phase during the data beats and keeps bip high.
    task automatic burst(input logic rd, input logic [15:0] a, input logic [1:0] sz,
                         input logic [63:0] wd, input int run, input int rst_beat,
                         input logic noise);
        int n;
        int r;
        n = 1 << sz;
        r = (run < n) ? run : n;
        if (rd) rd_seen.delete();
        step(rd, !rd, a, sz, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < r; b++) begin
            logic [16:0] ba;
            logic        inw;
            logic [7:0]  ed;
            logic [7:0]  wb;
            ba  = {1'b0, a} + 17'(b);
            inw = (ba >= {1'b0, BASE}) && (ba < {1'b0, BASE} + 17'(DEPTH));
            ed  = (rd && inw) ? mem_m[8'(ba - {1'b0, BASE})] : 8'h00;
            wb  = wd[8*b +: 8];
            for (int k = 0; k <= W; k++) begin
                logic compl;
                logic bp;
                logic rs;
                compl = (k == W);
                bp    = (b != r - 1) || (noise && r == n);
                rs    = compl && (b == rst_beat);
                step(noise, 1'b0, noise ? 16'h0010 : 16'h0000, 2'b00, bp, rd ? 8'h00 : wb, rs,
                     ed, rd, (k < W), !inw, rd && compl);
                if (compl && !rd && inw && !rs) mem_m[8'(ba - {1'b0, BASE})] = wb;
                if (rs) return;
            end
        end
    endtask

    task automatic expect_reads(input string nm, input int n, input logic [63:0] vals);
        chkint({nm, "_count"}, rd_seen.size(), n);
        for (int i = 0; i < n; i++)
            chk8(nm, (i < rd_seen.size()) ? rd_seen[i] : 8'hxx, vals[8*i +: 8]);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        chk = 1'b0; cap = 1'b0; oe_cnt = 0;
        exp_do = 8'h00; exp_oe = 1'b0; exp_wt = 1'b0; exp_er = 1'b0;
        ubus_reset = 1'b1; ubus_read = 1'b0; ubus_write = 1'b0; ubus_bip = 1'b0;
        ubus_addr = 16'h0000; ubus_size = 2'b00; ubus_data_in = 8'h00;
        @(posedge clk); #1;
        step(1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);

        // single write then back-to-back single read
        burst(1'b0, 16'h0010, 2'b00, 64'hA5, 1, -1, 1'b0);
        burst(1'b1, 16'h0010, 2'b00, 64'h0, 1, -1, 1'b0);
        idle(1'b0);
        expect_reads("t1_read", 1, 64'hA5);

        // 8-beat write, then 8-beat read with ignored address phases and bip held high
        burst(1'b0, 16'h0020, 2'b11, 64'h0807060504030201, 8, -1, 1'b0);
        idle(1'b0);
        burst(1'b1, 16'h0020, 2'b11, 64'h0, 8, -1, 1'b1);
        expect_reads("t2_read", 8, 64'h0807060504030201);
        burst(1'b1, 16'h0010, 2'b00, 64'h0, 1, -1, 1'b0);
        expect_reads("t2_b2b", 1, 64'hA5);
        idle(1'b0);

        // burst running off the window end, no wrap to offset 0
        burst(1'b0, 16'h0000, 2'b01, 64'h4D3C, 2, -1, 1'b0);
        burst(1'b0, 16'h00FE, 2'b01, 64'hC2C1, 2, -1, 1'b0);
        burst(1'b1, 16'h00FE, 2'b10, 64'h0, 4, -1, 1'b0);
        expect_reads("t3_edge", 4, 64'h0000C2C1);
        burst(1'b0, 16'h00FE, 2'b10, 64'hD4D3D2D1, 4, -1, 1'b0);
        burst(1'b1, 16'h0000, 2'b01, 64'h0, 2, -1, 1'b0);
        expect_reads("t3_nowrap", 2, 64'h4D3C);
        burst(1'b1, 16'h00FE, 2'b01, 64'h0, 2, -1, 1'b0);
        expect_reads("t3_inwin", 2, 64'hD2D1);
        idle(1'b0);

        // read+write collision in window, then out-of-window accesses
        step(1'b1, 1'b1, 16'h0005, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        step(1'b1, 1'b0, 16'h0300, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        step(1'b1, 1'b1, 16'h0300, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // beat timing, then reset in the completing cycle of a write's 2nd beat
        oe_cnt = 0;
        burst(1'b1, 16'h0020, 2'b01, 64'h0, 2, -1, 1'b0);
        idle(1'b0);
        chkint("oe_cycles", oe_cnt, 2 * (W + 1));
        expect_reads("t5_read", 2, 64'h0201);
        burst(1'b0, 16'h0040, 2'b01, 64'h6B5A, 2, -1, 1'b0);
        burst(1'b0, 16'h0040, 2'b01, 64'h2211, 2, 1, 1'b0);
        idle(1'b0);
        burst(1'b1, 16'h0040, 2'b01, 64'h0, 2, -1, 1'b0);
        expect_reads("t5_reset", 2, 64'h6B11);
        idle(1'b0);

        // early termination then back-to-back read
        burst(1'b0, 16'h0050, 2'b10, 64'h74737271, 4, -1, 1'b0);
        burst(1'b0, 16'h0050, 2'b10, 64'hE4E3E2E1, 2, -1, 1'b0);
        burst(1'b1, 16'h0050, 2'b10, 64'h0, 4, -1, 1'b0);
        expect_reads("t6_early", 4, 64'h7473E2E1);
        idle(1'b0);
        idle(1'b0);

        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
